// File: rtl/fetch_pkg.sv
// Shared fetch definitions: opcode constants, fetch FSM states, reset PC and immediate decoders.
package fetch_pkg;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_0000_0000;

  typedef enum logic [1:0] {REQ, WAIT, HOLD, DROP} fetch_state_e;

  function automatic logic [63:0] j_imm(input logic [31:0] instr);
    return {{44{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

  function automatic logic [63:0] b_imm(input logic [31:0] instr);
    return {{52{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_predecode.sv
// Combinational pre-decode of the held instruction: RAS push/pop intent and predicted next PC.
// Backward-taken branch prediction is enabled by defining FETCH_BTFN_EN.
module fetch_predecode
  import fetch_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [63:0] pc,
  input  logic [63:0] ras_rdata,
  input  logic        ras_valid,
  output logic        is_push,
  output logic        is_pop,
  output logic [63:0] pred_npc
);

  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic        rd_link;
  logic        rs1_link;
  logic [63:0] pc_seq;
  logic [63:0] ras_npc;
  logic        unused_ok;

  assign opcode   = instr[6:0];
  assign rd       = instr[11:7];
  assign rs1      = instr[19:15];
  assign rd_link  = (rd == 5'd1) || (rd == 5'd5);
  assign rs1_link = (rs1 == 5'd1) || (rs1 == 5'd5);
  assign pc_seq   = pc + 64'd4;
  // An empty RAS reports ras_valid = 0, so a return falls back to sequential fetch.
  assign ras_npc  = ras_valid ? {ras_rdata[63:1], 1'b0} : pc_seq;
  assign unused_ok = ^{instr[14:12], ras_rdata[0]};

`ifdef FETCH_BTFN_EN
  logic [63:0] br_off;
  assign br_off = b_imm(instr);
`endif

  always_comb begin
    is_push  = 1'b0;
    is_pop   = 1'b0;
    pred_npc = pc_seq;
    case (opcode)
      OP_JAL: begin
        pred_npc = pc + j_imm(instr);
        is_push  = rd_link;
      end
      OP_JALR: begin
        // Pop wins when both are links but differ: the RAS takes one strobe per cycle.
        if (rs1_link && (!rd_link || (rd != rs1))) begin
          is_pop   = 1'b1;
          pred_npc = ras_npc;
        end else if (rd_link) begin
          is_push = 1'b1;
        end
      end
`ifdef FETCH_BTFN_EN
      OP_BRANCH: begin
        if (br_off[63]) pred_npc = pc + br_off;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC controller: one outstanding imem request, pre-decoded handoff to decode, RAS strobes.
// Optional macro FETCH_BTFN_EN (in fetch_predecode) predicts backward branches taken.
module fetch_pc_ctrl
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [63:0] if_pc,
  output logic [31:0] if_instr,
  output logic [63:0] if_pred_npc,
  output logic        ras_push,
  output logic        ras_pop,
  output logic [63:0] ras_wdata,
  input  logic [63:0] ras_rdata,
  input  logic        ras_valid,
  input  logic        ras_full,
  input  logic        ras_empty,
  input  logic        ex_redirect,
  input  logic [63:0] ex_target
);

  fetch_state_e state, state_nxt;
  logic [63:0]  pc, pc_nxt;
  logic [31:0]  instr_q;
  logic         hold;
  logic         accept;
  logic         is_push;
  logic         is_pop;
  logic [63:0]  pred_npc;
  logic         unused_ok;

  // The RAS itself resolves overflow and underflow; the flags are not needed here.
  assign unused_ok = ^{ras_full, ras_empty};

  fetch_predecode u_predecode (
    .instr     (instr_q),
    .pc        (pc),
    .ras_rdata (ras_rdata),
    .ras_valid (ras_valid),
    .is_push   (is_push),
    .is_pop    (is_pop),
    .pred_npc  (pred_npc)
  );

  assign hold   = (state == HOLD);
  assign accept = hold && if_ready && !ex_redirect;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    case (state)
      REQ:  if (imem_gnt) state_nxt = ex_redirect ? DROP : WAIT;
      WAIT: begin
        if (imem_rvalid)      state_nxt = ex_redirect ? REQ : HOLD;
        else if (ex_redirect) state_nxt = DROP;
      end
      HOLD: if (ex_redirect || if_ready) state_nxt = REQ;
      DROP: if (imem_rvalid) state_nxt = REQ;
      default: state_nxt = REQ;
    endcase
    if (ex_redirect)  pc_nxt = {ex_target[63:2], 2'b00};
    else if (accept)  pc_nxt = pred_npc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= REQ;
      pc      <= RESET_PC;
      instr_q <= 32'd0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if ((state == WAIT) && imem_rvalid && !ex_redirect) instr_q <= imem_rdata;
    end
  end

  assign imem_req    = rst && (state == REQ);
  assign imem_addr   = pc;
  assign if_valid    = hold;
  assign if_pc       = hold ? pc : 64'd0;
  assign if_instr    = hold ? instr_q : 32'd0;
  assign if_pred_npc = hold ? pred_npc : 64'd0;
  assign ras_push    = accept && is_push;
  assign ras_pop     = accept && is_pop;
  assign ras_wdata   = pc + 64'd4;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Randomized scoreboard bench for fetch_pc_ctrl against a behavioural fetch/predict model.
module tb_fetch_pc_ctrl;

  localparam logic [63:0] RST_PC = 64'h0;
  localparam int NCYC = 4000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        if_valid, if_ready;
  logic [63:0] if_pc, if_pred_npc;
  logic [31:0] if_instr;
  logic        ras_push, ras_pop, ras_valid, ras_full, ras_empty;
  logic [63:0] ras_wdata, ras_rdata;
  logic        ex_redirect;
  logic [63:0] ex_target;

  fetch_pc_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc),
    .if_instr(if_instr), .if_pred_npc(if_pred_npc),
    .ras_push(ras_push), .ras_pop(ras_pop), .ras_wdata(ras_wdata),
    .ras_rdata(ras_rdata), .ras_valid(ras_valid), .ras_full(ras_full),
    .ras_empty(ras_empty), .ex_redirect(ex_redirect), .ex_target(ex_target)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] pc; logic [31:0] instr; } ho_t;
  ho_t ho_q[$];

  int          checks = 0;
  int          failures = 0;
  int          handoffs = 0;
  logic [63:0] exp_fetch;
  bit          outstanding = 0;
  bit          stale = 0;
  int          resp_wait = 0;
  logic [63:0] out_pc;
  logic [31:0] out_instr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] r;
    logic [4:0]  a, b;
    r = $urandom();
    a = 5'($urandom_range(0, 3));
    b = 5'($urandom_range(0, 3));
    a = (a == 5'd0) ? 5'd0 : (a == 5'd1) ? 5'd1 : (a == 5'd2) ? 5'd5 : 5'd6;
    b = (b == 5'd0) ? 5'd0 : (b == 5'd1) ? 5'd1 : (b == 5'd2) ? 5'd5 : 5'd6;
    case ($urandom_range(0, 7))
      0: return 32'h0000_0013;
      1: return 32'h1000_00EF;
      2: return 32'h0000_8067;
      3: return 32'hFE00_0CE3;
      4: return {r[31:12], a, 7'b1101111};
      5: return {r[31:20], b, 3'b000, a, 7'b1100111};
      6: return {r[31:7], 7'b1100011};
      default: return r;
    endcase
  endfunction

  // Prediction rules stated directly: immediates are rebuilt as signed integers.
  function automatic void model(input logic [31:0] ins, input logic [63:0] pc,
                                input logic [63:0] rd_ras, input bit rv,
                                output logic [63:0] npc, output bit push, output bit pop);
    int     rd, rs1;
    bit     lrd, lrs;
    longint u, off;
    logic [63:0] ret;
    rd  = int'(ins[11:7]);
    rs1 = int'(ins[19:15]);
    lrd = (rd == 1) || (rd == 5);
    lrs = (rs1 == 1) || (rs1 == 5);
    ret = rv ? (rd_ras & ~64'd1) : pc + 64'd4;
    npc = pc + 64'd4;
    push = 0;
    pop = 0;
    if (ins[6:0] == 7'h6F) begin
      u = (longint'(ins[31]) << 20) + (longint'(ins[19:12]) << 12) +
          (longint'(ins[20]) << 11) + (longint'(ins[30:21]) << 1);
      off = ins[31] ? u - (longint'(1) << 21) : u;
      npc = pc + 64'(off);
      push = lrd;
    end else if (ins[6:0] == 7'h67) begin
      if (lrd && lrs) begin
        if (rd == rs1) push = 1;
        else begin pop = 1; npc = ret; end
      end else if (lrd) push = 1;
      else if (lrs) begin pop = 1; npc = ret; end
    end
`ifdef FETCH_BTFN_EN
    else if (ins[6:0] == 7'h63) begin
      u = (longint'(ins[31]) << 12) + (longint'(ins[7]) << 11) +
          (longint'(ins[30:25]) << 5) + (longint'(ins[11:8]) << 1);
      off = ins[31] ? u - 8192 : u;
      if (off < 0) npc = pc + 64'(off);
    end
`endif
  endfunction

  // Stimulus and model bookkeeping
  initial begin
    logic [63:0] t;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0; if_ready = 0;
    ras_rdata = 0; ras_valid = 0; ras_full = 0; ras_empty = 1;
    ex_redirect = 0; ex_target = 0;
    exp_fetch = RST_PC;
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("reset_imem_req", imem_req, 0);
    chk("reset_if_valid", if_valid, 0);
    chk("reset_ras_strobes", {ras_push, ras_pop}, 0);
    chk("reset_if_pc", if_pc, 0);
    chk("reset_if_instr", if_instr, 0);
    chk("reset_if_pred_npc", if_pred_npc, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      imem_gnt = 0;
      imem_rvalid = 0;
      imem_rdata = $urandom();
      if (!outstanding && imem_req) imem_gnt = ($urandom_range(0, 3) != 0);
      if (outstanding) begin
        if (resp_wait == 0) begin
          imem_rvalid = 1;
          imem_rdata = out_instr;
        end else resp_wait--;
      end
      if_ready = ($urandom_range(0, 2) != 0);
      ras_valid = $urandom_range(0, 1) == 1;
      ras_empty = !ras_valid;
      ras_full = $urandom_range(0, 3) == 0;
      ras_rdata = ($urandom_range(0, 1) == 1) ? 64'h44 : {$urandom(), $urandom()};
      ex_redirect = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 4))
        0: t = 64'h40;
        1: t = 64'h80;
        2: t = 64'h200;
        3: t = 64'h1000;
        default: t = {$urandom(), $urandom()};
      endcase
      ex_target = t | 64'($urandom_range(0, 3));
      #2;
      if (imem_gnt) begin
        outstanding = 1;
        stale = 0;
        resp_wait = $urandom_range(0, 2);
        out_pc = exp_fetch;
        out_instr = gen_instr();
      end else if (imem_rvalid) begin
        outstanding = 0;
        if (!stale && !ex_redirect) ho_q.push_back('{out_pc, out_instr});
        stale = 0;
      end
      if (ex_redirect) begin
        if (outstanding) stale = 1;
        exp_fetch = ex_target & ~64'd3;
        ho_q.delete();
      end
    end
    chk("handoff_progress", 64'(handoffs > 100), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Monitor: compares every cycle after reset release
  initial begin
    logic [63:0] npc;
    bit push, pop;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        chk("imem_req", imem_req, 64'(!outstanding && ho_q.size() == 0));
        chk("if_valid", if_valid, 64'(ho_q.size() != 0));
        if (imem_req && imem_gnt) chk("imem_addr", imem_addr, exp_fetch);
        if (ho_q.size() != 0) begin
          chk("if_pc", if_pc, ho_q[0].pc);
          chk("if_instr", if_instr, ho_q[0].instr);
          model(ho_q[0].instr, ho_q[0].pc, ras_rdata, ras_valid, npc, push, pop);
          chk("if_pred_npc", if_pred_npc, npc);
          if (if_ready && !ex_redirect) begin
            chk("ras_push", ras_push, push);
            chk("ras_pop", ras_pop, pop);
            if (push) chk("ras_wdata", ras_wdata, ho_q[0].pc + 64'd4);
            exp_fetch = npc;
            handoffs++;
            void'(ho_q.pop_front());
          end else begin
            chk("ras_idle_stall", {ras_push, ras_pop}, 0);
          end
        end else begin
          chk("ras_idle", {ras_push, ras_pop}, 0);
        end
      end
    end
  end

endmodule
